// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates and lock status
// from asynchronous hsync/vsync, checking every line and frame length.
module vga_sync_decoder #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_active,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_error
);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_START  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END    = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] V_LINES  = 11'(V_TOTAL);
  localparam logic [9:0]  CNT_MAX  = 10'd1023;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  logic       hsync_s1_q, hsync_s2_q, hsync_prev_q;
  logic       vsync_s1_q, vsync_s2_q, vsync_prev_q;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] line_cnt_q, line_cnt_d;
  state_t     state_q;
  logic [1:0] good_frames_q;
  logic       first_line_q;
  logic       locked_q, frame_start_q, sync_error_q;
  logic       video_active_q;
  logic [9:0] pixel_x_q, pixel_y_q;

  logic        h_fall, v_fall;
  logic        line_bad, frame_bad;
  logic [10:0] frame_lines;
  logic        in_area;

  // Sync inputs idle high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      hsync_s1_q   <= 1'b1;
      hsync_s2_q   <= 1'b1;
      hsync_prev_q <= 1'b1;
      vsync_s1_q   <= 1'b1;
      vsync_s2_q   <= 1'b1;
      vsync_prev_q <= 1'b1;
    end else begin
      hsync_s1_q   <= hsync_in;
      hsync_s2_q   <= hsync_s1_q;
      hsync_prev_q <= hsync_s2_q;
      vsync_s1_q   <= vsync_in;
      vsync_s2_q   <= vsync_s1_q;
      vsync_prev_q <= vsync_s2_q;
    end
  end

  assign h_fall = hsync_prev_q & ~hsync_s2_q;
  assign v_fall = vsync_prev_q & ~vsync_s2_q;

  // A coincident hsync fall still belongs to the frame that is ending.
  assign frame_lines = {1'b0, line_cnt_q} + {10'd0, h_fall};
  assign line_bad    = h_fall & ~first_line_q & (h_cnt_q != H_LAST);
  assign frame_bad   = v_fall & (frame_lines != V_LINES);

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (h_fall) begin
      h_cnt_d = 10'd0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (v_fall) begin
      line_cnt_d = 10'd0;
    end else if (h_fall && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= 10'd0;
      line_cnt_q <= 10'd0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  // The first hsync fall after (re)entering SEARCH ends a line of unknown start.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      good_frames_q <= 2'd0;
      first_line_q  <= 1'b1;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
      if (h_fall) begin
        first_line_q <= 1'b0;
      end
      case (state_q)
        SEARCH: begin
          if (v_fall) begin
            state_q       <= ACQUIRE;
            good_frames_q <= 2'd0;
          end
        end
        ACQUIRE: begin
          if (line_bad || frame_bad) begin
            state_q      <= SEARCH;
            sync_error_q <= 1'b1;
            first_line_q <= 1'b1;
          end else if (v_fall) begin
            frame_start_q <= 1'b1;
            good_frames_q <= good_frames_q + 2'd1;
            if (good_frames_q == 2'd1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (line_bad || frame_bad) begin
            state_q      <= SEARCH;
            sync_error_q <= 1'b1;
            first_line_q <= 1'b1;
            locked_q     <= 1'b0;
          end else if (v_fall) begin
            frame_start_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_area = (h_cnt_q >= H_START) && (h_cnt_q <= H_END) &&
                   (line_cnt_q >= V_START) && (line_cnt_q <= V_END);

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      video_active_q <= 1'b0;
      pixel_x_q      <= 10'd0;
      pixel_y_q      <= 10'd0;
    end else if (locked_q && in_area) begin
      video_active_q <= 1'b1;
      pixel_x_q      <= h_cnt_q - H_START;
      pixel_y_q      <= line_cnt_q - V_START;
    end else begin
      video_active_q <= 1'b0;
      pixel_x_q      <= 10'd0;
      pixel_y_q      <= 10'd0;
    end
  end

  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign video_active = video_active_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a scaled-down timing set
// so that many whole frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int H_TOTAL = 100;
  localparam int H_SYNC  = 10;
  localparam int H_BP    = 6;
  localparam int H_ACT   = 70;
  localparam int V_TOTAL = 20;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 3;
  localparam int V_ACT   = 12;
  // Pin fall -> h_cnt=0 takes 3 edges, plus one edge for the output register.
  localparam int LAT     = H_SYNC + H_BP + 4;

  logic       clk_25MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       hsync_in  = 1'b1;
  logic       vsync_in  = 1'b1;
  logic [9:0] pixel_x, pixel_y;
  logic       video_active, frame_start, locked, sync_error;

  int testCount = 0;
  int failCount = 0;
  int errPulses = 0;
  int fsPulses  = 0;

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT)
  ) dut (
    .clk_25MHz   (clk_25MHz),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_active(video_active),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_error  (sync_error)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Pulse outputs are tallied on the falling edge, away from register updates.
  always @(negedge clk_25MHz) begin
    if (sync_error) errPulses++;
    if (frame_start) fsPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".pixel_x"}, 32'(pixel_x), 0);
    checkOutput({tag, ".pixel_y"}, 32'(pixel_y), 0);
    checkOutput({tag, ".video_active"}, 32'(video_active), 0);
    checkOutput({tag, ".frame_start"}, 32'(frame_start), 0);
    checkOutput({tag, ".locked"}, 32'(locked), 0);
    checkOutput({tag, ".sync_error"}, 32'(sync_error), 0);
  endtask

  // One line of len clocks; mode 1 checks an active row, mode 2 an inactive row.
  task automatic applyStimulus(input int len, input bit vLow, input int mode,
                               input int expY);
    for (int c = 0; c < len; c++) begin
      @(posedge clk_25MHz);
      #1;
      hsync_in = (c < H_SYNC) ? 1'b0 : 1'b1;
      vsync_in = vLow ? 1'b0 : 1'b1;
      if (mode == 1) begin
        if (c == LAT - 1) checkOutput("preActive.va", 32'(video_active), 0);
        if (c == LAT) begin
          checkOutput("firstPix.va", 32'(video_active), 1);
          checkOutput("firstPix.x", 32'(pixel_x), 0);
          checkOutput("firstPix.y", 32'(pixel_y), 32'(expY));
        end
        if (c == LAT + 10) checkOutput("midPix.x", 32'(pixel_x), 10);
        if (c == LAT + H_ACT - 1) begin
          checkOutput("lastPix.va", 32'(video_active), 1);
          checkOutput("lastPix.x", 32'(pixel_x), 32'(H_ACT - 1));
        end
        if (c == LAT + H_ACT) begin
          checkOutput("postActive.va", 32'(video_active), 0);
          checkOutput("postActive.x", 32'(pixel_x), 0);
        end
      end else if (mode == 2) begin
        if (c == LAT) begin
          checkOutput("blankRow.va", 32'(video_active), 0);
          checkOutput("blankRow.y", 32'(pixel_y), 0);
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_25MHz);
      #1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
    end
  endtask

  task automatic sendFrame(input int lines, input int shortIdx, input int shortLen,
                           input bit chk);
    for (int l = 0; l < lines; l++) begin
      int len;
      int mode;
      int y;
      len  = (l == shortIdx) ? shortLen : H_TOTAL;
      mode = 0;
      y    = 0;
      if (chk) begin
        if (l == V_SYNC + V_BP - 1 || l == V_SYNC + V_BP + V_ACT) begin
          mode = 2;
        end else if (l == V_SYNC + V_BP) begin
          mode = 1;
          y    = 0;
        end else if (l == V_SYNC + V_BP + V_ACT - 1) begin
          mode = 1;
          y    = V_ACT - 1;
        end
      end
      applyStimulus(len, l < V_SYNC, mode, y);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_25MHz);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    // Two good frames are needed after the first accepted vsync fall.
    sendFrame(V_TOTAL, -1, 0, 0);
    sendFrame(V_TOTAL, -1, 0, 0);
    checkOutput("acq.locked", 32'(locked), 0);
    checkOutput("acq.errors", 32'(errPulses), 0);
    checkOutput("acq.frameStarts", 32'(fsPulses), 1);

    sendFrame(V_TOTAL, -1, 0, 1);
    checkOutput("lock.locked", 32'(locked), 1);
    checkOutput("lock.frameStarts", 32'(fsPulses), 2);
    checkOutput("lock.errors", 32'(errPulses), 0);

    // Short line while locked.
    sendFrame(V_TOTAL, 7, H_TOTAL - 1, 0);
    checkOutput("shortLine.errors", 32'(errPulses), 1);
    checkOutput("shortLine.locked", 32'(locked), 0);
    sendFrame(V_TOTAL, -1, 0, 0);
    checkOutput("search.frameStarts", 32'(fsPulses), 3);
    sendFrame(V_TOTAL, -1, 0, 0);
    checkOutput("relock1.locked", 32'(locked), 0);
    sendFrame(V_TOTAL, -1, 0, 1);
    checkOutput("relock.locked", 32'(locked), 1);
    checkOutput("relock.errors", 32'(errPulses), 1);
    checkOutput("relock.frameStarts", 32'(fsPulses), 5);

    // Frame one line short.
    sendFrame(V_TOTAL - 1, -1, 0, 0);
    checkOutput("preShortFrame.frameStarts", 32'(fsPulses), 6);
    sendFrame(V_TOTAL, -1, 0, 0);
    checkOutput("shortFrame.errors", 32'(errPulses), 2);
    checkOutput("shortFrame.locked", 32'(locked), 0);
    checkOutput("shortFrame.frameStarts", 32'(fsPulses), 6);

    sendFrame(V_TOTAL, -1, 0, 0);
    sendFrame(V_TOTAL, -1, 0, 0);
    for (int l = 0; l < 10; l++) applyStimulus(H_TOTAL, l < V_SYNC, 0, 0);
    applyStimulus(50, 1'b0, 0, 0);
    checkOutput("preReset.locked", 32'(locked), 1);

    // Asynchronous reset in the middle of a line.
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    idleCycles(3);
    rst_n = 1'b1;
    idleCycles(47);
    for (int l = 11; l < V_TOTAL; l++) applyStimulus(H_TOTAL, 1'b0, 0, 0);
    sendFrame(V_TOTAL, -1, 0, 0);
    sendFrame(V_TOTAL, -1, 0, 0);
    checkOutput("postReset.locked", 32'(locked), 0);
    checkOutput("postReset.errors", 32'(errPulses), 2);
    sendFrame(V_TOTAL, -1, 0, 1);
    checkOutput("postReset.relock", 32'(locked), 1);
    checkOutput("final.errors", 32'(errPulses), 2);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
